// File: rtl/sig_cfg_ctrl_pkg.sv
// sig_cfg_ctrl_pkg
// Shared definitions for the signal-generator configuration controller:
// FSM state encoding, edited-field encoding, default timing parameters,
// and the key-event priority helper.
package sig_cfg_ctrl_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_RESTART = 2'd2;

  // Field under edit
  localparam logic [1:0] FIELD_SIG   = 2'd0;
  localparam logic [1:0] FIELD_AMP   = 2'd1;
  localparam logic [1:0] FIELD_FRE   = 2'd2;
  localparam logic [1:0] FIELD_PHASE = 2'd3;

  // Default timing
  localparam logic [19:0] DB_CYCLES_DEFAULT      = 20'd1_000_000;
  localparam logic [3:0]  RESTART_CYCLES_DEFAULT = 4'd2;

  // One-cycle press events after priority resolution (at most one bit set)
  typedef struct packed {
    logic run;
    logic sel;
    logic inc;
  } key_events_t;

  // run beats sel beats inc; losers in the same cycle are dropped
  function automatic key_events_t prioritize(input logic run,
                                             input logic sel,
                                             input logic inc);
    key_events_t e;
    e.run = run;
    e.sel = sel & ~run;
    e.inc = inc & ~run & ~sel;
    return e;
  endfunction

endpackage

// File: rtl/sig_cfg_ctrl_key_debounce.sv
// key_debounce
// Synchronizes, debounces and edge-detects one active-low raw key.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   key   - raw button input, low when pressed
//   press - one-cycle pulse, the cycle after the debounced level falls
module key_debounce
  import sig_cfg_ctrl_pkg::*;
#(
  parameter logic [19:0] DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  logic        sync0;
  logic        sync1;
  logic        level;
  logic        level_q;
  logic [19:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0   <= 1'b1;
      sync1   <= 1'b1;
      level   <= 1'b1;
      level_q <= 1'b1;
      cnt     <= 20'd0;
      press   <= 1'b0;
    end else begin
      sync0   <= key;
      sync1   <= sync0;
      level_q <= level;
      // Falling edge of the debounced level only; release makes no event
      press   <= level_q & ~level;
      if (sync1 == level) begin
        cnt <= 20'd0;
      end else if (cnt >= DB_CYCLES - 20'd1) begin
        // DB_CYCLES consecutive disagreeing samples seen, including this one
        level <= sync1;
        cnt   <= 20'd0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/sig_cfg_ctrl.sv
// sig_cfg_ctrl
// Three-button configuration controller for a waveform generator. Keys are
// debounced into press events that edit four 2-bit fields and start/stop the
// generator; editing while running forces a short confirm-low restart.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   key_sel, key_inc, key_run   - raw active-low buttons
//   cnt_sig/amp/fre/phase       - field codes to the generator
//   confirm                     - generator run enable
//   field_sel                   - field under edit
//   running                     - high whenever the FSM is not IDLE
//   fsm_state                   - current FSM state, for observation
module sig_cfg_ctrl
  import sig_cfg_ctrl_pkg::*;
#(
  parameter logic [19:0] DB_CYCLES      = DB_CYCLES_DEFAULT,
  parameter logic [3:0]  RESTART_CYCLES = RESTART_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_sel,
  input  logic       key_inc,
  input  logic       key_run,
  output logic [1:0] cnt_sig,
  output logic [1:0] cnt_amp,
  output logic [1:0] cnt_fre,
  output logic [1:0] cnt_phase,
  output logic       confirm,
  output logic [1:0] field_sel,
  output logic       running,
  output logic [1:0] fsm_state
);

  logic press_sel;
  logic press_inc;
  logic press_run;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_sel),
    .press (press_sel)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_inc),
    .press (press_inc)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_run),
    .press (press_run)
  );

  key_events_t ev;
  assign ev = prioritize(press_run, press_sel, press_inc);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] rcnt;
  logic [3:0] rcnt_nxt;

  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    case (state)
      ST_IDLE: begin
        if (ev.run) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (ev.run) begin
          state_nxt = ST_IDLE;
        end else if (ev.inc) begin
          state_nxt = ST_RESTART;
          rcnt_nxt  = 4'd0;
        end
      end
      ST_RESTART: begin
        if (ev.run) begin
          state_nxt = ST_IDLE;
          rcnt_nxt  = 4'd0;
        end else if (ev.inc) begin
          // Another edit restarts the low window from the beginning
          rcnt_nxt = 4'd0;
        end else if (rcnt >= RESTART_CYCLES - 4'd1) begin
          state_nxt = ST_RUN;
          rcnt_nxt  = 4'd0;
        end else begin
          rcnt_nxt = rcnt + 4'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        rcnt_nxt  = 4'd0;
      end
    endcase
  end

  // confirm/running are registered from the next state so they change on the
  // same edge as the state itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rcnt    <= 4'd0;
      confirm <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      rcnt    <= rcnt_nxt;
      confirm <= (state_nxt == ST_RUN);
      running <= (state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_sel <= FIELD_SIG;
      cnt_sig   <= 2'd0;
      cnt_amp   <= 2'd0;
      cnt_fre   <= 2'd0;
      cnt_phase <= 2'd0;
    end else begin
      if (ev.sel) field_sel <= field_sel + 2'd1;
      if (ev.inc) begin
        case (field_sel)
          FIELD_SIG:   cnt_sig   <= cnt_sig + 2'd1;
          FIELD_AMP:   cnt_amp   <= cnt_amp + 2'd1;
          FIELD_FRE:   cnt_fre   <= cnt_fre + 2'd1;
          default:     cnt_phase <= cnt_phase + 2'd1;
        endcase
      end
    end
  end

endmodule
